// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types, defaults and config check for the sequence detector
package seq_det_pkg;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_ARMED} seq_state_e;

    localparam int SEQ_MAX_LEN_DEF = 8;

    function automatic logic len_ok(input int unsigned len, input int unsigned max);
        return (len != 0) && (len <= max);
    endfunction

endpackage

// File: rtl/seq_hist_shreg.sv
// rtl/seq_hist_shreg.sv - stream history shift register with saturating fill counter
module seq_hist_shreg #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic               bit_in,
    input  logic               clr,
    input  logic               fill_clr,
    output logic [MAX_LEN-1:0] hist,
    output logic [LEN_W-1:0]   fill
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= {hist[MAX_LEN-2:0], bit_in};
            // fill_clr restarts counting after a non-overlapping match; history keeps shifting
            if (fill_clr)
                fill <= '0;
            else if (fill != LEN_W'(MAX_LEN))
                fill <= fill + LEN_W'(1);
        end
    end

endmodule

// File: rtl/seq_det_param.sv
// rtl/seq_det_param.sv - run-time programmable serial pattern detector with match counter
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = SEQ_MAX_LEN_DEF,
    parameter int CNT_W   = 8,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cfg_moore,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    seq_state_e         state;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic               moore_q;
    logic               moore_out_q;

    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W:0]     fill_p1;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic               load_legal;
    logic               accept;
    logic               fill_ok;
    logic               match;

    assign load_legal = cfg_load && len_ok({{(32-LEN_W){1'b0}}, cfg_len}, MAX_LEN);
    // a bit arriving with a load is dropped, and nothing is accepted while unconfigured
    assign accept     = in_valid && !cfg_load && (state != S_IDLE);
    assign fill_p1    = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
    assign fill_ok    = fill_p1 >= {1'b0, len_q};
    assign window     = {hist[MAX_LEN-2:0], in_bit};

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < 32'(len_q));
    end

    assign match = accept && fill_ok && (((window ^ pat_q) & mask) == '0);
    assign out   = moore_q ? moore_out_q : match;

    seq_hist_shreg #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .bit_in   (in_bit),
        .clr      (load_legal),
        .fill_clr (match && !overlap_q),
        .hist     (hist),
        .fill     (fill)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            overlap_q   <= 1'b0;
            moore_q     <= 1'b0;
            moore_out_q <= 1'b0;
            match_cnt   <= '0;
            cfg_err     <= 1'b0;
        end else begin
            if (cnt_clr)
                match_cnt <= '0;
            else if (match && (match_cnt != '1))
                match_cnt <= match_cnt + CNT_W'(1);

            if (cfg_load) begin
                moore_out_q <= 1'b0;
                if (load_legal) begin
                    pat_q     <= cfg_pattern;
                    len_q     <= cfg_len;
                    overlap_q <= cfg_overlap;
                    moore_q   <= cfg_moore;
                    cfg_err   <= 1'b0;
                    state     <= S_FILL;
                end else begin
                    cfg_err   <= 1'b1;
                    state     <= S_IDLE;
                end
            end else begin
                if (in_valid)
                    moore_out_q <= match;
                case (state)
                    S_FILL: begin
                        if (accept && fill_ok)
                            state <= (match && !overlap_q) ? S_FILL : S_ARMED;
                    end
                    S_ARMED: begin
                        if (match && !overlap_q)
                            state <= S_FILL;
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_det_param.sv
// tb/tb_seq_det_param.sv - directed self-checking bench for seq_det_param
module tb_seq_det_param;
    import seq_det_pkg::*;

    localparam int ML = 8;
    localparam int LW = $clog2(ML + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_bit = 1'b0;
    logic          cfg_load = 1'b0;
    logic [ML-1:0] cfg_pattern = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          cfg_overlap = 1'b0;
    logic          cfg_moore = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          out, out2, cfg_err, cfg_err2;
    logic [7:0]    match_cnt;
    logic [1:0]    match_cnt2;

    int tests = 0;
    int fails = 0;

    logic [7:0] mh;
    int         mf;
    int         mcnt;
    logic       mlast;
    logic       m;
    logic       b;
    logic [5:0] lfsr;

    always #5 clk = ~clk;

    seq_det_param #(.MAX_LEN(ML), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_moore(cfg_moore), .cnt_clr(cnt_clr),
        .out(out), .match_cnt(match_cnt), .cfg_err(cfg_err)
    );

    seq_det_param #(.MAX_LEN(ML), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_moore(cfg_moore), .cnt_clr(cnt_clr),
        .out(out2), .match_cnt(match_cnt2), .cfg_err(cfg_err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_load = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic load(input logic [7:0] pat, input logic [LW-1:0] len, input logic ov, input logic mo);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        cfg_moore   = mo;
        tick();
    endtask

    // bits/exp listed oldest-first from bit n-1 down to bit 0; Mealy out checked before the edge
    task automatic stream_mealy(input logic [7:0] bits, input int n, input logic [7:0] exp, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            in_valid = 1'b1;
            in_bit   = bits[i];
            #1;
            chk($sformatf("%s[%0d]", tag, n - 1 - i), {31'b0, out}, {31'b0, exp[i]});
            tick();
        end
    endtask

    function automatic logic ref_match(input logic [7:0] h, input int f, input logic bi,
                                       input logic [7:0] p, input int len);
        logic [7:0] w;
        logic [7:0] msk;
        w   = {h[6:0], bi};
        msk = 8'((9'd1 << len) - 9'd1);
        return (f + 1 >= len) && (((w ^ p) & msk) == 8'h00);
    endfunction

    initial begin
        #12;
        chk("rst_out", {31'b0, out}, 0);
        chk("rst_cnt", {24'b0, match_cnt}, 0);
        chk("rst_err", {31'b0, cfg_err}, 0);
        rst = 1'b1;
        tick();

        load(8'b01011, 5, 1'b1, 1'b0);
        stream_mealy(8'b01011, 5, 8'b00001, "mealy5");
        chk("mealy5_cnt", {24'b0, match_cnt}, 1);

        load(8'b101, 3, 1'b1, 1'b0);
        stream_mealy(8'b10101, 5, 8'b00101, "ovl");
        chk("ovl_cnt", {24'b0, match_cnt}, 3);
        load(8'b101, 3, 1'b0, 1'b0);
        stream_mealy(8'b10101, 5, 8'b00100, "novl");
        chk("novl_cnt", {24'b0, match_cnt}, 4);

        load(8'b01011, 5, 1'b1, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            in_valid = 1'b1;
            in_bit   = (i == 2 || i == 0);
            tick();
            chk($sformatf("moore_fill[%0d]", 3 - i), {31'b0, out}, 0);
        end
        in_valid = 1'b1; in_bit = 1'b1; #1;
        chk("moore_pre_edge", {31'b0, out}, 0);
        tick();
        chk("moore_rise", {31'b0, out}, 1);
        tick();
        chk("moore_gap1", {31'b0, out}, 1);
        tick();
        chk("moore_gap2", {31'b0, out}, 1);
        in_valid = 1'b1; in_bit = 1'b0; #1;
        chk("moore_hold_pre", {31'b0, out}, 1);
        tick();
        chk("moore_fall", {31'b0, out}, 0);
        chk("moore_cnt", {24'b0, match_cnt}, 5);

        load(8'b01011, 0, 1'b1, 1'b0);
        chk("err_len0", {31'b0, cfg_err}, 1);
        stream_mealy(8'b01011, 5, 8'b00000, "err0");
        load(8'b01011, LW'(ML + 1), 1'b1, 1'b0);
        chk("err_lenmax1", {31'b0, cfg_err}, 1);
        stream_mealy(8'b01011, 5, 8'b00000, "err9");
        chk("err_cnt", {24'b0, match_cnt}, 5);
        load(8'b01011, 5, 1'b1, 1'b0);
        chk("err_clear", {31'b0, cfg_err}, 0);
        stream_mealy(8'b01011, 5, 8'b00001, "post_err");

        cnt_clr = 1'b1;
        tick();
        chk("clr_cnt", {24'b0, match_cnt}, 0);
        chk("clr_cnt2", {30'b0, match_cnt2}, 0);
        load(8'b1, 1, 1'b1, 1'b0);
        stream_mealy(8'h1f, 5, 8'h1f, "len1");
        chk("sat_cnt8", {24'b0, match_cnt}, 5);
        chk("sat_cnt2", {30'b0, match_cnt2}, 3);
        in_valid = 1'b1; in_bit = 1'b1; cnt_clr = 1'b1; #1;
        chk("clr_vs_match_out", {31'b0, out}, 1);
        tick();
        chk("clr_vs_match", {24'b0, match_cnt}, 0);
        chk("clr_vs_match2", {30'b0, match_cnt2}, 0);

        // len = MAX_LEN uses the full history
        load(8'b10110011, 8, 1'b0, 1'b0);
        stream_mealy(8'b10110011, 8, 8'b00000001, "maxlen");

        lfsr = 6'b000111;
        for (int mo = 0; mo < 2; mo++) begin
            cnt_clr = 1'b1;
            tick();
            load(8'b01011, 5, (mo == 0), mo[0]);
            mh = '0; mf = 0; mcnt = 0; mlast = 1'b0;
            for (int i = 0; i < 500; i++) begin
                if (i % 7 == 3) begin
                    tick();
                    if (mo == 1) chk($sformatf("lfsr_gap_%0d", i), {31'b0, out}, {31'b0, mlast});
                end
                b    = lfsr[0];
                lfsr = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
                m    = ref_match(mh, mf, b, 8'b01011, 5);
                in_valid = 1'b1;
                in_bit   = b;
                #1;
                if (mo == 0) chk($sformatf("lfsr_mealy_%0d", i), {31'b0, out}, {31'b0, m});
                tick();
                if (mo == 1) chk($sformatf("lfsr_moore_%0d", i), {31'b0, out}, {31'b0, m});
                mh = {mh[6:0], b};
                if (m && mo == 1) mf = 0;
                else if (mf < 8) mf++;
                mcnt += int'(m);
                mlast = m;
            end
            chk($sformatf("lfsr_cnt_%0d", mo), {24'b0, match_cnt}, mcnt);
            chk($sformatf("lfsr_cnt2_%0d", mo), {30'b0, match_cnt2}, (mcnt > 3) ? 3 : mcnt);
        end

        load(8'b01011, 5, 1'b1, 1'b0);
        stream_mealy(8'b0101, 4, 8'b0000, "pre_rst");
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_out", {31'b0, out}, 0);
        chk("mid_rst_cnt", {24'b0, match_cnt}, 0);
        @(negedge clk);
        rst = 1'b1;
        load(8'b01011, 5, 1'b1, 1'b0);
        stream_mealy(8'b1, 1, 8'b0, "straddle");
        stream_mealy(8'b01011, 5, 8'b00001, "post_rst");
        chk("post_rst_cnt", {24'b0, match_cnt}, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
